serial_adder: RTL and testbench

- Bit-serial, LSB-first ripple adder: one full-adder cell plus a carry flip-flop, one bit per clock.
- Used for area-constrained datapaths.
- Counterpart to the existing combinational subtractor cells: performs addition, the inverse operation, sequentially.
- Start/busy/done handshake; result held until the next accepted operation.

---
 rtl/serial_adder.sv | 150 +++++++++++++++
 tb/tb_serial_adder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder, one full-adder cell per clock.
// Optional subtract mode (a-b, borrow on cout) when SERIAL_ADDER_SUB_EN is defined.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_a_q, shift_a_d;
    logic [WIDTH-1:0] shift_b_q, shift_b_d;
    logic [WIDTH-1:0] shift_s_q, shift_s_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sub_q, sub_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             load_sub;
    logic             accept;
    logic             bit_s;
    logic             carry_nxt;
    logic [WIDTH-1:0] shift_s_nxt;

`ifdef SERIAL_ADDER_SUB_EN
    assign load_sub = sub;
`else
    assign load_sub = 1'b0;
`endif

    // Full-adder cell on the current LSBs plus the running carry
    always_comb begin
        bit_s       = shift_a_q[0] ^ shift_b_q[0] ^ carry_q;
        carry_nxt   = (shift_a_q[0] & shift_b_q[0]) |
                      (shift_a_q[0] & carry_q) |
                      (shift_b_q[0] & carry_q);
        shift_s_nxt = {bit_s, shift_s_q[WIDTH-1:1]};
        accept      = start && (state_q == IDLE || state_q == DONE);
    end

    // Next-state and datapath update; start is only honoured in IDLE/DONE
    always_comb begin
        state_d   = state_q;
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        shift_s_d = shift_s_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        sub_d     = sub_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    // Subtraction is a + ~b + 1: invert b and seed the carry
                    shift_a_d = a;
                    shift_b_d = load_sub ? ~b : b;
                    carry_d   = load_sub;
                    sub_d     = load_sub;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = ADD;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            ADD: begin
                shift_a_d = shift_a_q >> 1;
                shift_b_d = shift_b_q >> 1;
                shift_s_d = shift_s_nxt;
                carry_d   = carry_nxt;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    // Borrow is the inverted carry in subtract mode
                    sum_d   = shift_s_nxt;
                    cout_d  = carry_nxt ^ sub_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_a_q <= '0;
            shift_b_q <= '0;
            shift_s_q <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            sub_q     <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            shift_s_q <= shift_s_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            sub_q     <= sub_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table-driven and scoreboard bench for serial_adder.
// Subtract cases run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
        logic             cout;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub_r;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int   tests;
    int   failures;
    int   done_cnt;
    int   cyc;
    exp_t sb[$];

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub_r),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse pops and compares the oldest expectation
    always @(negedge clk) begin
        if (rst_n && busy && done)
            check("busy_and_done", 32'd1, 32'd0);
        if (rst_n && done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sum", 32'(sum), 32'(e.sum));
                check("cout", 32'(cout), 32'(e.cout));
            end
        end
    end

    function automatic exp_t model(input logic [WIDTH-1:0] ma,
                                   input logic [WIDTH-1:0] mb,
                                   input logic ms);
        exp_t r;
        logic [WIDTH:0] t;
        if (ms) begin
            r.sum  = ma - mb;
            r.cout = (ma < mb);
        end else begin
            t      = {1'b0, ma} + {1'b0, mb};
            r.sum  = t[WIDTH-1:0];
            r.cout = t[WIDTH];
        end
        return r;
    endfunction

    task automatic drive(input logic [WIDTH-1:0] ta,
                         input logic [WIDTH-1:0] tb_v,
                         input logic ts, input exp_t e);
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        sub_r = ts;
        sb.push_back(e);
    endtask

    // Counts edges until done, bounded; also counts busy samples seen
    task automatic wait_done(output int n, output int nbusy);
        n     = 0;
        nbusy = 0;
        while (!done && n < WIDTH + 4) begin
            if (busy) nbusy++;
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] ta,
                          input logic [WIDTH-1:0] tb_v,
                          input logic ts, input exp_t e);
        int n;
        int nb;
        drive(ta, tb_v, ts, e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        wait_done(n, nb);
        check("latency", 32'(n), 32'(WIDTH));
        check("busy_cycles", 32'(nb), 32'(WIDTH));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        exp_t e;
        int   n;
        int   nb;
        int   c1;
        int   dsnap;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        vecs[0] = '{a: 8'hFF, b: 8'h01, sum: 8'h00, cout: 1'b1};
        vecs[1] = '{a: 8'hFF, b: 8'hFF, sum: 8'hFE, cout: 1'b1};
        vecs[2] = '{a: 8'h00, b: 8'h00, sum: 8'h00, cout: 1'b0};
        vecs[3] = '{a: 8'h80, b: 8'h7F, sum: 8'hFF, cout: 1'b0};
        vecs[4] = '{a: 8'hAA, b: 8'h55, sum: 8'hFF, cout: 1'b0};
        vecs[5] = '{a: 8'h01, b: 8'hFF, sum: 8'h00, cout: 1'b1};

        tests    = 0;
        failures = 0;
        done_cnt = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        sub_r    = 1'b0;

        idle(2);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        e = '{sum: 8'h96, cout: 1'b0};
        run_op(8'h3C, 8'h5A, 1'b0, e);
        for (int i = 0; i < 20; i++) begin
            check("hold_sum", 32'(sum), 32'h96);
            check("hold_cout", 32'(cout), 32'd0);
            idle(1);
        end

        for (int i = 0; i < 6; i++) begin
            e = '{sum: vecs[i].sum, cout: vecs[i].cout};
            run_op(vecs[i].a, vecs[i].b, 1'b0, e);
        end

        for (int i = 0; i < 8; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            run_op(ra, rb, 1'b0, model(ra, rb, 1'b0));
        end

        // start during busy must be ignored
        drive(8'h10, 8'h20, 1'b0, '{sum: 8'h30, cout: 1'b0});
        @(posedge clk);
        #1;
        start = 1'b0;
        idle(2);
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        idle(1);
        start = 1'b0;
        wait_done(n, nb);
        check("ignored_start_latency", 32'(n), 32'(WIDTH - 3));
        idle(2);

        // reset in the middle of an operation
        drive(8'h3C, 8'h5A, 1'b0, '{sum: 8'h96, cout: 1'b0});
        @(posedge clk);
        #1;
        start = 1'b0;
        idle(3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        dsnap = done_cnt;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        idle(12);
        check("abort_no_done", 32'(done_cnt), 32'(dsnap));
        run_op(8'h01, 8'h02, 1'b0, '{sum: 8'h03, cout: 1'b0});

        // back-to-back: restart in the DONE cycle
        drive(8'h12, 8'h34, 1'b0, '{sum: 8'h46, cout: 1'b0});
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n, nb);
        check("b2b_first_latency", 32'(n), 32'(WIDTH));
        c1 = cyc;
        drive(8'h80, 8'h80, 1'b0, '{sum: 8'h00, cout: 1'b1});
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n, nb);
        check("b2b_gap", 32'(cyc - c1), 32'(WIDTH + 1));
        idle(2);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h05, 8'h07, 1'b1, '{sum: 8'hFE, cout: 1'b1});
        run_op(8'h07, 8'h05, 1'b1, '{sum: 8'h02, cout: 1'b0});
        run_op(8'h07, 8'h05, 1'b0, '{sum: 8'h0C, cout: 1'b0});
        for (int i = 0; i < 4; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            run_op(ra, rb, 1'b1, model(ra, rb, 1'b1));
        end
`endif

        idle(3);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
